// File: rtl/bta_accum_ctrl.sv
// bta_accum_ctrl: job sequencer for the shared 4-operand binary-tree adder.
// It takes 1..NMAX operands from a valid/ready stream and packs them into
// groups of four. Each group is issued to the adder, and the adder's group
// sums are accumulated into a wide result.
// Ports:
//   clk, rst               rising-edge clock, async active-high reset
//   start, count           job request; count is latched when start is accepted
//   in_valid/in_data       operand stream; in_ready = accepted this cycle
//   busy                   job in progress (COLLECT/ISSUE/WAIT)
//   add_a..add_d, add_cin  adder operands (slot regs 0..3), carry-in tied 0
//   add_vld                one-cycle issue strobe
//   add_sum                adder group sum (valid ADD_LAT clocks after issue)
//   done, result           done pulse; result held until the next accepted start
//   err                    one-cycle pulse on an illegal count
module bta_accum_ctrl #(
  parameter int unsigned W       = 16,
  parameter int unsigned NMAX    = 64,
  parameter int unsigned ADD_LAT = 1,
  parameter int unsigned ACC_W   = W + $clog2(NMAX)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [$clog2(NMAX):0]   count,
  input  logic                    in_valid,
  input  logic [W-1:0]            in_data,
  output logic                    in_ready,
  output logic                    busy,
  output logic [W-1:0]            add_a,
  output logic [W-1:0]            add_b,
  output logic [W-1:0]            add_c,
  output logic [W-1:0]            add_d,
  output logic                    add_cin,
  output logic                    add_vld,
  input  logic [W+1:0]            add_sum,
  output logic                    done,
  output logic [ACC_W-1:0]        result,
  output logic                    err
);

  localparam int unsigned CW       = $clog2(NMAX) + 1;
  localparam int unsigned LCW      = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
  localparam bit          COMB_ADD = (ADD_LAT == 0);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    rem;
  logic [2:0]       idx;
  logic [LCW-1:0]   cnt;
  logic [W-1:0]     slot [4];
  logic [ACC_W-1:0] acc;

  logic idle_like_c, start_ok_c, start_bad_c, hs_c, sample_c;

  assign add_a   = slot[0];
  assign add_b   = slot[1];
  assign add_c   = slot[2];
  assign add_d   = slot[3];
  assign add_cin = 1'b0;

  // Next-state decode; the group sum is sampled ADD_LAT clocks after issue.
  always_comb begin
    state_n     = state;
    idle_like_c = (state == S_IDLE) || (state == S_DONE);
    start_ok_c  = idle_like_c && start && (count != '0) && (count <= CW'(NMAX));
    start_bad_c = idle_like_c && start && !start_ok_c;
    hs_c        = in_valid && in_ready;
    sample_c    = ((state == S_ISSUE) && COMB_ADD) ||
                  ((state == S_WAIT) && (cnt == '0));
    case (state)
      S_IDLE, S_DONE: begin
        if (start_ok_c)            state_n = S_COLLECT;
        else                       state_n = S_IDLE;
      end
      S_COLLECT: begin
        if (hs_c && ((idx == 3'd3) || (rem == CW'(1)))) state_n = S_ISSUE;
      end
      S_ISSUE: begin
        if (!COMB_ADD)             state_n = S_WAIT;
        else if (rem == '0)        state_n = S_DONE;
        else                       state_n = S_COLLECT;
      end
      S_WAIT: begin
        if (sample_c)              state_n = (rem == '0) ? S_DONE : S_COLLECT;
      end
      default:                     state_n = S_IDLE;
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      rem      <= '0;
      idx      <= '0;
      cnt      <= '0;
      acc      <= '0;
      result   <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      add_vld  <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      for (int i = 0; i < 4; i++) slot[i] <= '0;
    end else begin
      state    <= state_n;
      in_ready <= (state_n == S_COLLECT);
      busy     <= (state_n == S_COLLECT) || (state_n == S_ISSUE) || (state_n == S_WAIT);
      add_vld  <= (state_n == S_ISSUE);
      done     <= (state_n == S_DONE);
      err      <= start_bad_c;

      if (start_ok_c) begin
        rem <= count;
        acc <= '0;
        idx <= '0;
        for (int i = 0; i < 4; i++) slot[i] <= '0;
      end

      if ((state == S_COLLECT) && hs_c) begin
        slot[idx[1:0]] <= in_data;
        idx            <= 3'(idx + 3'd1);
        rem            <= CW'(rem - CW'(1));
      end

      if ((state == S_ISSUE) && !COMB_ADD) cnt <= LCW'(ADD_LAT - 1);
      if ((state == S_WAIT) && (cnt != '0)) cnt <= LCW'(cnt - LCW'(1));

      // Accumulate; either finish the job or clear slots for the next group.
      if (sample_c) begin
        acc <= acc + ACC_W'(add_sum);
        if (rem == '0) begin
          result <= acc + ACC_W'(add_sum);
        end else begin
          idx <= '0;
          for (int i = 0; i < 4; i++) slot[i] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bta_accum_ctrl.sv
// Testbench for bta_accum_ctrl. Three instances (ADD_LAT = 0, 1, 3) are each
// paired with a delayed-sum adder model. A job-level reference model predicts
// the result (a plain sum of the operands), the number of issues, the
// zero-padded group contents and the done latency.
module tb_bta_accum_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_s    [3];
  logic [6:0]  count_s    [3];
  logic        in_valid_s [3];
  logic [15:0] in_data_s  [3];
  logic        in_ready_s [3];
  logic        busy_s     [3];
  logic [15:0] add_a_s    [3];
  logic [15:0] add_b_s    [3];
  logic [15:0] add_c_s    [3];
  logic [15:0] add_d_s    [3];
  logic        add_cin_s  [3];
  logic        add_vld_s  [3];
  logic [17:0] add_sum_s  [3];
  logic        done_s     [3];
  logic [21:0] result_s   [3];
  logic        err_s      [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    logic [17:0] s0;
    logic [17:0] pipe [3];
    // External adder: combinational sum, delayed by L clocks.
    assign s0 = 18'(add_a_s[g]) + 18'(add_b_s[g]) + 18'(add_c_s[g]) +
                18'(add_d_s[g]) + 18'(add_cin_s[g]);
    always_ff @(posedge clk) begin
      pipe[0] <= s0;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign add_sum_s[g] = (L == 0) ? s0 : pipe[(L == 0) ? 0 : L - 1];

    bta_accum_ctrl #(.W(16), .NMAX(64), .ADD_LAT(L)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start_s[g]),
      .count    (count_s[g]),
      .in_valid (in_valid_s[g]),
      .in_data  (in_data_s[g]),
      .in_ready (in_ready_s[g]),
      .busy     (busy_s[g]),
      .add_a    (add_a_s[g]),
      .add_b    (add_b_s[g]),
      .add_c    (add_c_s[g]),
      .add_d    (add_d_s[g]),
      .add_cin  (add_cin_s[g]),
      .add_vld  (add_vld_s[g]),
      .add_sum  (add_sum_s[g]),
      .done     (done_s[g]),
      .result   (result_s[g]),
      .err      (err_s[g])
    );
  end

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_res [3];
  logic [15:0] ops [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  function automatic logic [15:0] slot_of(input int k, input int j);
    case (j)
      0:       return add_a_s[k];
      1:       return add_b_s[k];
      2:       return add_c_s[k];
      default: return add_d_s[k];
    endcase
  endfunction

  // Runs one job on instance k with the operands in ops[].
  task automatic run_job(input int k, input bit gaps, input bit stray);
    int          cnt = ops.size();
    logic [63:0] sum = 0;
    int          i = 0, issues = 0, cyc = 0, last_hs = -100;
    bit          got_done = 0, stray_done = 0;
    foreach (ops[n]) sum += 64'(ops[n]);
    @(negedge clk);
    start_s[k] = 1'b1;
    count_s[k] = 7'(cnt);
    @(negedge clk);
    start_s[k] = 1'b0;
    check("busy_after_start", 64'(busy_s[k]), 64'd1);
    while (!got_done && cyc < 3000) begin
      if (add_vld_s[k]) begin
        check("in_ready_in_issue", 64'(in_ready_s[k]), 64'd0);
        for (int j = 0; j < 4; j++) begin
          int p = 4 * issues + j;
          check($sformatf("slot%0d_grp%0d", j, issues), 64'(slot_of(k, j)),
                (p < cnt) ? 64'(ops[p]) : 64'd0);
        end
        issues++;
      end
      if (err_s[k]) check("err_during_job", 64'(err_s[k]), 64'd0);
      if (done_s[k]) begin
        got_done = 1;
        start_s[k]    = 1'b0;
        in_valid_s[k] = 1'b0;
        check("result", 64'(result_s[k]), sum);
        check("issues", 64'(issues), 64'((cnt + 3) / 4));
        check("done_latency", 64'(cyc - last_hs), 64'(lat_of(k) + 2));
        exp_res[k] = sum;
      end else begin
        if (i < cnt && (!gaps || $urandom_range(0, 2) != 0)) begin
          in_valid_s[k] = 1'b1;
          in_data_s[k]  = ops[i];
        end else begin
          in_valid_s[k] = 1'b0;
          in_data_s[k]  = 16'($urandom);
        end
        if (stray && !stray_done && busy_s[k] && $urandom_range(0, 3) == 0) begin
          start_s[k] = 1'b1;
          count_s[k] = 7'($urandom_range(0, 70));
          stray_done = 1;
        end else begin
          start_s[k] = 1'b0;
        end
        if (in_valid_s[k] && in_ready_s[k]) begin
          i++;
          last_hs = cyc;
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (!got_done) check("done_timeout", 64'd0, 64'd1);
    @(negedge clk);
    check("done_one_cycle", 64'(done_s[k]), 64'd0);
    check("idle_after_done", 64'(busy_s[k]), 64'd0);
  endtask

  // Illegal count: err pulse, no job, result untouched.
  task automatic err_test(input int k, input int cnt);
    @(negedge clk);
    start_s[k] = 1'b1;
    count_s[k] = 7'(cnt);
    @(negedge clk);
    start_s[k] = 1'b0;
    check($sformatf("err_cnt%0d", cnt), 64'(err_s[k]), 64'd1);
    check("err_no_busy", 64'(busy_s[k]), 64'd0);
    check("err_no_done", 64'(done_s[k]), 64'd0);
    @(negedge clk);
    check("err_pulse_end", 64'(err_s[k]), 64'd0);
    check("err_busy_later", 64'(busy_s[k]), 64'd0);
    check("err_result_kept", 64'(result_s[k]), exp_res[k]);
  endtask

  task automatic fill(input int n, input bit all_ones);
    ops.delete();
    for (int i = 0; i < n; i++) ops.push_back(all_ones ? 16'hFFFF : 16'($urandom));
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0; count_s[k] = '0; in_valid_s[k] = 1'b0; in_data_s[k] = '0;
      exp_res[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_result", 64'(result_s[k]), 64'd0);
      check("rst_busy", 64'(busy_s[k]), 64'd0);
      check("rst_in_ready", 64'(in_ready_s[k]), 64'd0);
      check("rst_flags", {61'd0, done_s[k], err_s[k], add_vld_s[k]}, 64'd0);
    end
    rst = 1'b0;

    // Directed jobs on the ADD_LAT=1 instance.
    ops = '{16'h5E3A, 16'hF0AE, 16'hE61E, 16'hF5C7};
    run_job(1, 0, 0);
    check("tp_count4", 64'(result_s[1]), 64'h32ACD);
    fill(5, 1);
    run_job(1, 0, 0);
    check("tp_count5", 64'(result_s[1]), 64'h4FFFB);
    fill(64, 1);
    run_job(1, 0, 0);
    check("tp_count64", 64'(result_s[1]), 64'h3FFFC0);
    err_test(1, 0);
    err_test(1, 65);

    // Randomized jobs with gaps and stray starts on every latency.
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < 6; r++) begin
        fill($urandom_range(1, 64), 0);
        run_job(k, 1, 1);
      end
      fill(64, 0);
      run_job(k, 1, 1);
      fill(1, 0);
      run_job(k, 1, 1);
    end

    // Reset mid-job after three operands of an 8-operand job.
    @(negedge clk);
    start_s[1] = 1'b1; count_s[1] = 7'd8;
    @(negedge clk);
    start_s[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid_s[1] = 1'b1; in_data_s[1] = 16'($urandom);
      @(negedge clk);
    end
    in_valid_s[1] = 1'b0;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) exp_res[k] = '0;
    check("midrst_busy", 64'(busy_s[1]), 64'd0);
    check("midrst_in_ready", 64'(in_ready_s[1]), 64'd0);
    check("midrst_result", 64'(result_s[1]), 64'd0);
    check("midrst_slots", {add_a_s[1], add_b_s[1], add_c_s[1], add_d_s[1]}, 64'd0);
    check("midrst_flags", {61'd0, done_s[1], err_s[1], add_vld_s[1]}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midrst_no_done", 64'(done_s[1]), 64'd0);
    end
    fill(4, 0);
    run_job(1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bta_accum_ctrl.md
Name: bta_accum_ctrl

Overview:
Job sequencer for the shared 4-operand binary-tree adder (BTA). It accepts a job of 1..NMAX W-bit operands on a valid/ready stream and packs them into groups of four. Each group is issued to the adder's A/B/C/D inputs, and the adder's (W+2)-bit group sum is accumulated into a wide result. Sits between the operand producer and one external BTA instance, which it owns exclusively for the duration of a job.

Parameters:
W, 16, operand width (one adder lane)
NMAX, 64, max operands per job (power of two, >=4)
ADD_LAT, 1, adder latency in clocks from issue to valid add_sum (0 = combinational)
ACC_W, W+$clog2(NMAX), result width (22 at defaults); overflow impossible by construction

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin job; sampled only in IDLE or DONE
count  in  $clog2(NMAX)+1  operands in job, latched on accepted start
in_valid  in  1  operand valid
in_data  in  W  operand
in_ready  out  1  operand accepted when in_valid & in_ready
busy  out  1  high in COLLECT/ISSUE/WAIT
add_a, add_b, add_c, add_d  out  W each  adder operands (slot regs 0..3)
add_cin  out  1  adder carry-in, tied 0
add_vld  out  1  one-cycle issue strobe
add_sum  in  W+2  adder group sum
done  out  1  one-cycle pulse, result valid
result  out  ACC_W  accumulated sum, held until next accepted start
err  out  1  one-cycle pulse, illegal count

Behaviour:
- Reset (async): state=IDLE; slots, acc, result=0; in_ready, busy, add_vld, done, err=0.
- FSM states: IDLE, COLLECT, ISSUE, WAIT, DONE.
- IDLE/DONE + start:
  - count==0 or count>NMAX: err=1 next cycle, stay IDLE, result unchanged.
  - else: latch rem=count, acc=0, slots=0, idx=0, go to COLLECT.
- start in COLLECT/ISSUE/WAIT: ignored.
- COLLECT:
  - in_ready=1. On handshake: slot[idx]=in_data, idx++, rem--.
  - When idx reaches 4 or rem reaches 0 on that edge, go to ISSUE.
  - Unfilled slots stay 0 (zero-padding for a partial last group).
  - in_valid gaps: FSM stays in COLLECT.
- ISSUE: add_vld=1 for exactly this cycle; in_ready=0.
  - ADD_LAT==0: acc += zero-extend(add_sum) this edge.
  - else: go to WAIT with cnt=ADD_LAT-1.
- WAIT: in_ready=0. add_a..d are held stable from ISSUE through the sampling cycle.
  - Sampling cycle is ADD_LAT clocks after ISSUE: acc += add_sum.
- After sampling:
  - rem>0: clear slots, idx=0, return to COLLECT.
  - rem==0: result=acc+add_sum, go to DONE.
- DONE: done=1 for one cycle, then behaves as IDLE (start accepted in the DONE cycle itself).
- Latency: last operand handshake edge -> done high is ADD_LAT+2 cycles.
- Issues per job: ceil(count/4). Exactly one group in flight; no overlap.
- rst mid-job: immediate abort to reset values. Partial data is discarded and no done is produced.

Test Plan:
- count=4, ADD_LAT=1, operands 0x5E3A,0xF0AE,0xE61E,0xF5C7 back-to-back -> single add_vld with add_a..d equal to those values in order; done 3 cycles after last handshake; result=0x32ACD.
- count=5, all operands 0xFFFF -> two issues, second issue has add_b=add_c=add_d=0; result=0x4FFFB.
- count=64, all 0xFFFF -> 16 issues; result=0x3FFFC0; no overflow.
- count=0, then count=65 -> err pulse each time; no busy, no done; result retains previous value.
- Random in_valid gaps, with start pulsed while busy -> in_ready=0 in ISSUE/WAIT; stray start ignored; result equals golden sum. Repeat with ADD_LAT=0 and ADD_LAT=3.
- rst asserted after 3 operands of a count=8 job -> all outputs 0 immediately, no done; a fresh count=4 job then returns the correct sum.
